mac_host_seq: RTL and testbench

- Host-side sequencer for the 4-lane 7-bit dot-product accelerator byte interface.
- Accepts one job (four data elements, optionally four weight elements) on a valid/ready port.
- Shifts the elements into the accelerator in 7-bit chunks, waits out the accelerator pipeline, then captures the two alternating result bytes.
- Returns the reassembled 16-bit dot product on a valid/ready output port. Sits between the system bus and the accelerator pins.

---
 rtl/mac_host_seq.sv | 190 +++++++++++++++++++
 tb/tb_mac_host_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_host_seq.sv
// Host-side sequencer for the 4-lane 7-bit dot-product accelerator: shifts one job in,
// waits out the accelerator pipeline, then reassembles the alternating result bytes.
module mac_host_seq #(
    parameter int LAT      = 2,
    parameter int READ_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [27:0] in_data,
    input  logic [27:0] in_weights,
    input  logic        in_load_w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_err,
    output logic        busy,
    output logic [7:0]  mac_ui,
    output logic [1:0]  mac_sel,
    input  logic [7:0]  mac_byte,
    input  logic        mac_phase
);

    localparam int CNT_W = $clog2(((READ_MAX > LAT) ? READ_MAX : LAT) + 4);

    localparam logic [1:0] SEL_DATA = 2'b00;
    localparam logic [1:0] SEL_WGT  = 2'b11;
    localparam logic [1:0] SEL_READ = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_D,
        S_LOAD_W,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lw_q;
    logic               lo_ok;
    logic               hi_ok;
    logic [27:0]        d_q;
    logic [27:0]        w_q;
    logic [7:0]         lo_q;
    logic [7:0]         hi_q;

    logic               accept;
    logic               load_last;
    logic               w_shift;
    logic               cap_lo_ok;
    logic               cap_hi_ok;
    logic [7:0]         cap_lo;
    logic [7:0]         cap_hi;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign load_last = (cnt == CNT_W'(3));
    // Weights shift out starting on the edge that leaves LOAD_D, so element 3 goes first.
    assign w_shift   = (state == S_LOAD_D && load_last && lw_q) || (state == S_LOAD_W);

    // The current cycle's sample counts toward completion.
    assign cap_lo_ok = lo_ok | mac_phase;
    assign cap_hi_ok = hi_ok | ~mac_phase;
    assign cap_lo    = mac_phase ? mac_byte : lo_q;
    assign cap_hi    = mac_phase ? hi_q : mac_byte;

    // Element shift registers and byte holding registers; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            d_q  <= in_data << 7;
            w_q  <= in_weights;
            lo_q <= 8'd0;
            hi_q <= 8'd0;
        end else begin
            if (state == S_LOAD_D) d_q <= d_q << 7;
            if (w_shift) w_q <= w_q << 7;
            if (state == S_CAPTURE) begin
                lo_q <= cap_lo;
                hi_q <= cap_hi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lw_q       <= 1'b0;
            lo_ok      <= 1'b0;
            hi_ok      <= 1'b0;
            mac_sel    <= SEL_IDLE;
            mac_ui     <= 8'd0;
            out_valid  <= 1'b0;
            out_err    <= 1'b0;
            out_result <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    mac_sel <= SEL_IDLE;
                    mac_ui  <= 8'd0;
                    if (accept) begin
                        lw_q    <= in_load_w;
                        lo_ok   <= 1'b0;
                        hi_ok   <= 1'b0;
                        cnt     <= '0;
                        state   <= S_LOAD_D;
                        mac_sel <= SEL_DATA;
                        mac_ui  <= {1'b0, in_data[27:21]};
                    end
                end
                S_LOAD_D: begin
                    if (load_last) begin
                        cnt <= '0;
                        if (lw_q) begin
                            state   <= S_LOAD_W;
                            mac_sel <= SEL_WGT;
                            mac_ui  <= {1'b0, w_q[27:21]};
                        end else begin
                            state   <= S_WAIT;
                            mac_sel <= SEL_READ;
                            mac_ui  <= 8'd0;
                        end
                    end else begin
                        cnt    <= cnt + 1'b1;
                        mac_ui <= {1'b0, d_q[27:21]};
                    end
                end
                S_LOAD_W: begin
                    if (load_last) begin
                        cnt     <= '0;
                        state   <= S_WAIT;
                        mac_sel <= SEL_READ;
                        mac_ui  <= 8'd0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        mac_ui <= {1'b0, w_q[27:21]};
                    end
                end
                S_WAIT: begin
                    if (cnt == CNT_W'(LAT - 1)) begin
                        cnt   <= '0;
                        state <= S_CAPTURE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    lo_ok <= cap_lo_ok;
                    hi_ok <= cap_hi_ok;
                    if (cap_lo_ok && cap_hi_ok) begin
                        out_result <= {cap_hi, cap_lo};
                        out_valid  <= 1'b1;
                        out_err    <= 1'b0;
                        state      <= S_DONE;
                        mac_sel    <= SEL_IDLE;
                    end else if (cnt == CNT_W'(READ_MAX - 1)) begin
                        // Missing byte reads as 0 since it was cleared at accept.
                        out_result <= {cap_hi, cap_lo};
                        out_valid  <= 1'b1;
                        out_err    <= 1'b1;
                        state      <= S_DONE;
                        mac_sel    <= SEL_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    mac_sel <= SEL_IDLE;
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        lo_ok     <= 1'b0;
                        hi_ok     <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mac_sel <= SEL_IDLE;
                    mac_ui  <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_host_seq.sv
// Directed bench for mac_host_seq with a behavioural accelerator model on the pins.
module tb_mac_host_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] in_data = '0;
    logic [27:0] in_weights = '0;
    logic        in_load_w = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic        out_err;
    logic        busy;
    logic [7:0]  mac_ui;
    logic [1:0]  mac_sel;
    logic [7:0]  mac_byte;
    logic        mac_phase;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mac_host_seq #(.LAT(2), .READ_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_weights(in_weights), .in_load_w(in_load_w),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_err(out_err), .busy(busy),
        .mac_ui(mac_ui), .mac_sel(mac_sel), .mac_byte(mac_byte), .mac_phase(mac_phase)
    );

    // Accelerator model: lanes shift toward lane 3, result register lags the lanes by
    // one cycle, byte register follows the result while sel = 10 with alternating phase.
    logic [6:0]  ld [4] = '{default: 7'd0};
    logic [6:0]  lw [4] = '{default: 7'd0};
    logic [15:0] res = 16'd0;
    logic [7:0]  mbyte = 8'd0;
    logic        mph = 1'b0;
    logic        ph_t = 1'b1;
    logic        start_ph = 1'b0;
    logic        stuck = 1'b0;
    logic        cur_ph;

    assign cur_ph    = stuck ? 1'b1 : ph_t;
    assign mac_byte  = mbyte;
    assign mac_phase = mph;

    always @(posedge clk) begin
        if (mac_sel == 2'b00) begin
            ld[3] <= ld[2]; ld[2] <= ld[1]; ld[1] <= ld[0]; ld[0] <= mac_ui[6:0];
        end
        if (mac_sel == 2'b11) begin
            lw[3] <= lw[2]; lw[2] <= lw[1]; lw[1] <= lw[0]; lw[0] <= mac_ui[6:0];
        end
        res <= 16'(ld[0]) * 16'(lw[0]) + 16'(ld[1]) * 16'(lw[1])
             + 16'(ld[2]) * 16'(lw[2]) + 16'(ld[3]) * 16'(lw[3]);
        if (mac_sel == 2'b10) begin
            mbyte <= cur_ph ? res[7:0] : res[15:8];
            mph   <= cur_ph;
            ph_t  <= ~ph_t;
        end else begin
            // The first sel=10 byte is stale; the first trusted one carries start_ph.
            ph_t <= ~start_ph;
        end
    end

    task automatic run_job(input logic [27:0] d, input logic [27:0] w, input logic lwf,
                           output int cyc, output int n00, output int n11, output int n10,
                           output logic [7:0] first_ui, output bit to);
        @(negedge clk);
        in_data = d; in_weights = w; in_load_w = lwf; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_data = ~d; in_weights = ~w; in_load_w = ~lwf;
        first_ui = mac_ui;
        cyc = 0; n00 = 0; n11 = 0; n10 = 0; to = 1'b0;
        while (out_valid !== 1'b1) begin
            if (cyc >= 40) begin
                to = 1'b1;
                break;
            end
            case (mac_sel)
                2'b00: n00++;
                2'b11: n11++;
                2'b10: n10++;
                default: ;
            endcase
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic finish_job();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (mac_sel !== 2'b01) begin bad++; $display("FAIL reset_sel got %b want 01", mac_sel); end
        total++; if (mac_ui !== 8'h00) begin bad++; $display("FAIL reset_ui got %h want 00", mac_ui); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", out_err); end
        total++; if (out_result !== 16'h0000) begin bad++; $display("FAIL reset_result got %h want 0000", out_result); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input logic ph, input string tag);
        int cyc, n00, n11, n10;
        logic [7:0] fu;
        bit to;
        start_ph = ph;
        run_job({7'd4, 7'd3, 7'd2, 7'd1}, {7'd8, 7'd7, 7'd6, 7'd5}, 1'b1, cyc, n00, n11, n10, fu, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL %s_timeout got %0d want 0", tag, to); end
        total++; if (out_result !== 16'h0046) begin bad++; $display("FAIL %s_result got %h want 0046", tag, out_result); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL %s_err got %b want 0", tag, out_err); end
        total++; if (n00 != 4) begin bad++; $display("FAIL %s_sel00 got %0d want 4", tag, n00); end
        total++; if (n11 != 4) begin bad++; $display("FAIL %s_sel11 got %0d want 4", tag, n11); end
        total++; if (n10 != 4) begin bad++; $display("FAIL %s_sel10 got %0d want 4", tag, n10); end
        total++; if (cyc != 12) begin bad++; $display("FAIL %s_latency got %0d want 12", tag, cyc); end
        total++; if (fu !== 8'h04) begin bad++; $display("FAIL %s_first_ui got %h want 04", tag, fu); end
        finish_job();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_handoff_valid got %b want 0", tag, out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_handoff_ready got %b want 1", tag, in_ready); end
    endtask

    task automatic test_reuse();
        int cyc, n00, n11, n10;
        logic [7:0] fu;
        bit to;
        start_ph = 1'b0;
        run_job({7'd1, 7'd1, 7'd1, 7'd1}, 28'hFFFFFFF, 1'b0, cyc, n00, n11, n10, fu, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL reuse_timeout got %0d want 0", to); end
        total++; if (out_result !== 16'h001A) begin bad++; $display("FAIL reuse_result got %h want 001a", out_result); end
        total++; if (n11 != 0) begin bad++; $display("FAIL reuse_sel11 got %0d want 0", n11); end
        total++; if (cyc != 8) begin bad++; $display("FAIL reuse_latency got %0d want 8", cyc); end
        finish_job();
    endtask

    task automatic test_max_backpressure();
        int cyc, n00, n11, n10;
        logic [7:0] fu;
        bit to;
        run_job(28'hFFFFFFF, 28'hFFFFFFF, 1'b1, cyc, n00, n11, n10, fu, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL max_timeout got %0d want 0", to); end
        total++; if (out_result !== 16'hFC04) begin bad++; $display("FAIL max_result got %h want fc04", out_result); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL max_err got %b want 0", out_err); end
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got %b want 1", i, out_valid); end
            total++; if (out_result !== 16'hFC04) begin bad++; $display("FAIL hold_result[%0d] got %h want fc04", i, out_result); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready[%0d] got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0;
        finish_job();
    endtask

    task automatic test_stuck_phase();
        int cyc, n00, n11, n10;
        logic [7:0] fu;
        bit to;
        stuck = 1'b1;
        run_job(28'hFFFFFFF, 28'h0000000, 1'b0, cyc, n00, n11, n10, fu, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL stuck_timeout got %0d want 0", to); end
        total++; if (out_err !== 1'b1) begin bad++; $display("FAIL stuck_err got %b want 1", out_err); end
        total++; if (out_result !== 16'h0004) begin bad++; $display("FAIL stuck_result got %h want 0004", out_result); end
        total++; if (cyc != 14) begin bad++; $display("FAIL stuck_latency got %0d want 14", cyc); end
        total++; if (n10 != 10) begin bad++; $display("FAIL stuck_sel10 got %0d want 10", n10); end
        finish_job();
        stuck = 1'b0;
    endtask

    task automatic test_reset_midjob();
        int cyc, n00, n11, n10;
        logic [7:0] fu;
        bit to;
        @(negedge clk);
        in_data = 28'h1234567; in_weights = 28'h7654321; in_load_w = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (mac_sel !== 2'b11) begin bad++; $display("FAIL midjob_in_loadw got %b want 11", mac_sel); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (mac_sel !== 2'b01) begin bad++; $display("FAIL midjob_sel got %b want 01", mac_sel); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midjob_busy got %b want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midjob_ready got %b want 1", in_ready); end
        total++; if (mac_ui !== 8'h00) begin bad++; $display("FAIL midjob_ui got %h want 00", mac_ui); end
        rst_n = 1'b1;
        start_ph = 1'b0;
        run_job({7'd4, 7'd3, 7'd2, 7'd1}, {7'd8, 7'd7, 7'd6, 7'd5}, 1'b1, cyc, n00, n11, n10, fu, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL midjob_timeout got %0d want 0", to); end
        total++; if (out_result !== 16'h0046) begin bad++; $display("FAIL midjob_result got %h want 0046", out_result); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL midjob_err got %b want 0", out_err); end
        finish_job();
    endtask

    initial begin
        test_reset();
        test_basic(1'b0, "phase0");
        test_basic(1'b1, "phase1");
        test_reuse();
        test_max_backpressure();
        test_stuck_phase();
        test_reset_midjob();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
